receive_packet_ddr: RTL and testbench
=====================================

// Module: receive_packet_ddr
// PURPOSE
//  Receive-side counterpart of the DDR packet sender. Accepts one Ethernet frame at a time from the
//  TSE Avalon-ST RX FIFO (ff_rx_*), packs the bytes into 256-bit words and writes them to DDR via the
//  wr_rq/action_done request port of avalon_mm_ddr. The frame image uses the layout the sender reads:
//  header word at start_ram_addr, bits[10:0] = length; data words from start_ram_addr+1 onward.
// PARAMETERS
//  MAX_LEN   1518  frame byte limit; longer frames are dropped
//  ADDR_W    25    DDR word address width
// PORTS
//  clk_original    in   1    single clock; every port is synchronous to it
//  rst_n           in   1    asynchronous active-low reset
//  rx_enable       in   1    level; when 1, a new frame may start in IDLE
//  start_ram_addr  in   25   header address; sampled on the SOP beat
//  ff_rx_data      in   8    RX byte
//  ff_rx_sop       in   1    first byte of frame
//  ff_rx_eop       in   1    last byte of frame
//  ff_rx_err       in   1    frame error; valid on the EOP beat
//  ff_rx_dval      in   1    beat valid
//  ff_rx_rdy       out  1    ready; a beat is accepted when dval&rdy (ready latency 0)
//  wr_rq           out  1    DDR write request; held until action_done
//  wr_adr          out  25   DDR word address
//  wr_data_avalon  out  256  DDR write word
//  byte_enable     out  32   always 32'hFFFF_FFFF
//  action_done     in   1    one-cycle pulse: current write completed
//  pkt_done        out  1    one-cycle pulse after the header write completes
//  pkt_len         out  11   length written to the header; valid with pkt_done
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except byte_enable; wr_rq falls immediately (async).
//  FSM states: IDLE, RECV, WAIT_WR, HDR, DONE, DROP.
//  IDLE: ff_rx_rdy=1. Non-SOP beats are discarded.
//   SOP beat with rx_enable=1: latch base=start_ram_addr, waddr=base+1, len=1, store byte, ->RECV.
//   SOP and EOP on the same beat: 1-byte frame; go straight to the flush step.
//  RECV: ff_rx_rdy=1. Each accepted beat stores the byte and increments len (11-bit).
//   Byte packing: byte b of the word goes to wr_data_avalon[(b/4)*32+31-8*(b%4) -: 8];
//   unused bytes are 0. 32nd byte accepted: ->WAIT_WR (ff_rx_rdy=0 from the next cycle).
//   EOP with err=0: flush the partial word if non-empty (WAIT_WR), then ->HDR.
//   EOP with err=1, len>MAX_LEN, or SOP arriving while in RECV: ->DROP.
//  WAIT_WR: wr_rq=1, wr_adr=waddr. On action_done: waddr++, clear the buffer,
//   return to RECV, or to HDR if EOP has already been seen. ff_rx_rdy=0 throughout.
//  HDR: write {245'd0,len} to base, or {256'd0} for a dropped frame. The header is written last,
//   so the sender never sees a partial frame. On action_done: ->DONE.
//  DONE: one-cycle pkt_done with pkt_len, then ->IDLE.
//  DROP: any pending data write completes first. Remaining beats up to EOP are accepted and
//   discarded (ff_rx_rdy=1); then ->HDR with length 0. A drop caused by SOP-in-RECV: the new frame
//   is lost; DROP ends on its EOP.
//  wr_rq, wr_adr and wr_data_avalon stay stable while wr_rq=1. No new request in the cycle
//   action_done is seen.
//  Latency: frame EOP to pkt_done = (final data write + header write) handshakes + 2 cycles.
// CONFIGURATION
//  RX_PKT_STATS_EN defined: adds outputs rx_pkt_cnt[15:0] (incremented on good pkt_done) and
//   rx_drop_cnt[15:0] (incremented on dropped frames). Both wrap at 16'hFFFF and reset to 0.
//  Not defined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package rx_ddr_pkg: state enum rx_state_t, WORD_BYTES=32, LEN_W=11, ADDR_W=25,
//   function byte_lane(b) returning the bit offset.
//  Sub-module rx_byte_packer: 32-byte assembly register with byte index, full flag and clear input.
//  Top module: FSM, address/length counters, DDR request register.
// TESTING
//  64-byte frame (bytes 0x00..0x3F), base=0x100, action_done 3 cycles after wr_rq ->
//   writes 0x101, 0x102, then header 0x100=64; word0[31:24]=0x00, [7:0]=0x03; pkt_done, pkt_len=64.
//  33-byte frame -> 2 data words; second word has the byte at [31:24] and zeros elsewhere;
//   header=33.
//  1-byte frame (SOP+EOP same beat, 0xA5) -> 0x101[31:24]=0xA5, header=1.
//  60-byte frame with ff_rx_err on EOP -> data words written, header=0, no good-frame count.
//  1600-byte frame -> DROP at byte 1519, header=0, remaining beats drained with ff_rx_rdy=1.
//  action_done delayed 20 cycles -> ff_rx_rdy=0 for the whole wait, no byte lost or duplicated;
//   rst_n low during WAIT_WR -> wr_rq=0 at once, IDLE after release.

Source files
------------

// File: rtl/rx_ddr_pkg.sv
// Shared types and constants for the DDR packet receiver.
package rx_ddr_pkg;

  localparam int unsigned WORD_BYTES = 32;
  localparam int unsigned LEN_W      = 11;
  localparam int unsigned ADDR_W     = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WAIT_WR,
    ST_HDR,
    ST_DONE,
    ST_DROP
  } rx_state_t;

  // MSB position of byte b inside a DDR word: big-endian within each 32-bit lane
  function automatic int unsigned byte_lane(input int unsigned b);
    return (b / 4) * 32 + 31 - 8 * (b % 4);
  endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// 32-byte word assembly register: appends one byte per write, clear has priority
// but a simultaneous write lands in byte 0 of the freshly cleared word.
module rx_byte_packer
  import rx_ddr_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr,
  input  logic                    i_clear,
  input  logic [7:0]              i_byte,
  output logic [WORD_BYTES*8-1:0] o_word,
  output logic [5:0]              o_idx,
  output logic                    o_full
);

  logic [WORD_BYTES*8-1:0] r_word;
  logic [5:0]              r_idx;

  assign o_word = r_word;
  assign o_idx  = r_idx;
  assign o_full = (r_idx == 6'(WORD_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
      if (i_wr) begin
        r_word[byte_lane(0) -: 8] <= i_byte;
        r_idx                     <= 6'd1;
      end
    end else if (i_wr && !o_full) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (r_idx == 6'(b)) r_word[byte_lane(b) -: 8] <= i_byte;
      end
      r_idx <= r_idx + 6'd1;
    end
  end

endmodule

// File: rtl/receive_packet_ddr.sv
// Receives one Avalon-ST frame at a time and writes it to DDR as 256-bit words,
// header last. Optional RX_PKT_STATS_EN adds good/dropped frame counters.
module receive_packet_ddr #(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned ADDR_W  = 25
)(
  input  logic                         clk_original,
  input  logic                         rst_n,
  input  logic                         rx_enable,
  input  logic [ADDR_W-1:0]            start_ram_addr,
  input  logic [7:0]                   ff_rx_data,
  input  logic                         ff_rx_sop,
  input  logic                         ff_rx_eop,
  input  logic                         ff_rx_err,
  input  logic                         ff_rx_dval,
  output logic                         ff_rx_rdy,
  output logic                         wr_rq,
  output logic [ADDR_W-1:0]            wr_adr,
  output logic [255:0]                 wr_data_avalon,
  output logic [31:0]                  byte_enable,
  input  logic                         action_done,
  output logic                         pkt_done,
  output logic [rx_ddr_pkg::LEN_W-1:0] pkt_len
`ifdef RX_PKT_STATS_EN
  ,
  output logic [15:0]                  rx_pkt_cnt,
  output logic [15:0]                  rx_drop_cnt
`endif
);

  import rx_ddr_pkg::*;

  rx_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, r_waddr, r_wr_adr, w_waddr_cur;
  logic [LEN_W-1:0]  r_len, r_pkt_len;
  logic              r_eop_seen, w_eop_nxt;
  logic              r_drop, r_rdy, w_rdy_nxt;
  logic              r_wr_rq, r_hdr, r_pkt_done;

  logic              w_acc, w_start, w_done, w_drop_now;
  logic [LEN_W:0]    w_len_inc;
  logic              w_pk_wr, w_pk_clr, w_pk_full;
  logic [5:0]        w_pk_idx;
  logic [255:0]      w_pk_word, w_hdr_word;

  assign w_acc      = ff_rx_dval & r_rdy;
  assign w_start    = (r_state == ST_IDLE) & w_acc & ff_rx_sop & rx_enable;
  assign w_done     = action_done & r_wr_rq;
  assign w_len_inc  = {1'b0, r_len} + (LEN_W+1)'(1);
  assign w_drop_now = ff_rx_sop | (ff_rx_eop & ff_rx_err) | (w_len_inc > (LEN_W+1)'(MAX_LEN));

  assign w_pk_wr  = (w_start | ((r_state == ST_RECV) & w_acc)) & ~w_pk_full;
  assign w_pk_clr = w_start | ((r_state == ST_WAIT_WR) & w_done) | (r_state == ST_DROP);

  rx_byte_packer u_packer (
    .clk     (clk_original),
    .rst_n   (rst_n),
    .i_wr    (w_pk_wr),
    .i_clear (w_pk_clr),
    .i_byte  (ff_rx_data),
    .o_word  (w_pk_word),
    .o_idx   (w_pk_idx),
    .o_full  (w_pk_full)
  );

  // The SOP beat requests straight out of IDLE before r_waddr is loaded
  assign w_waddr_cur = (r_state == ST_IDLE) ? start_ram_addr + ADDR_W'(1) : r_waddr;
  assign w_hdr_word  = r_drop ? '0 : 256'(r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_eop_nxt   = r_eop_seen;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_eop_nxt = ff_rx_eop;
          if (ff_rx_eop) w_state_nxt = ff_rx_err ? ST_DROP : ST_WAIT_WR;
          else           w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_acc) begin
          w_eop_nxt = ff_rx_eop;
          if (w_drop_now)
            w_state_nxt = ST_DROP;
          else if (ff_rx_eop || w_pk_idx == 6'(WORD_BYTES-1))
            w_state_nxt = ST_WAIT_WR;
        end
      end
      ST_WAIT_WR: if (w_done) w_state_nxt = r_eop_seen ? ST_HDR : ST_RECV;
      ST_HDR:     if (w_done) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      ST_DROP: begin
        if (r_eop_seen) begin
          w_state_nxt = ST_HDR;
        end else if (w_acc && ff_rx_eop) begin
          w_state_nxt = ST_HDR;
          w_eop_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_rdy_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RECV) ||
                ((w_state_nxt == ST_DROP) && !w_eop_nxt);
  end

  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_waddr    <= '0;
      r_len      <= '0;
      r_eop_seen <= 1'b0;
      r_drop     <= 1'b0;
      r_rdy      <= 1'b0;
      r_wr_rq    <= 1'b0;
      r_wr_adr   <= '0;
      r_hdr      <= 1'b0;
      r_pkt_done <= 1'b0;
      r_pkt_len  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_eop_seen <= w_eop_nxt;
      r_rdy      <= w_rdy_nxt;
      r_pkt_done <= 1'b0;

      if (w_start) begin
        r_base  <= start_ram_addr;
        r_waddr <= start_ram_addr + ADDR_W'(1);
        r_len   <= LEN_W'(1);
        r_drop  <= ff_rx_eop & ff_rx_err;
      end
      if (r_state == ST_RECV && w_acc) begin
        r_len <= w_len_inc[LEN_W-1:0];
        if (w_drop_now) r_drop <= 1'b1;
      end
      if (r_state == ST_WAIT_WR && w_done) r_waddr <= r_waddr + ADDR_W'(1);

      // Header request waits one idle cycle after the last data handshake
      if (w_done) begin
        r_wr_rq <= 1'b0;
      end else if (w_state_nxt == ST_WAIT_WR && r_state != ST_WAIT_WR) begin
        r_wr_rq  <= 1'b1;
        r_wr_adr <= w_waddr_cur;
        r_hdr    <= 1'b0;
      end else if (r_state == ST_HDR && !r_wr_rq) begin
        r_wr_rq  <= 1'b1;
        r_wr_adr <= r_base;
        r_hdr    <= 1'b1;
      end

      if (r_state == ST_HDR && w_done) begin
        r_pkt_done <= 1'b1;
        r_pkt_len  <= r_drop ? '0 : r_len;
      end
    end
  end

`ifdef RX_PKT_STATS_EN
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) begin
      rx_pkt_cnt  <= '0;
      rx_drop_cnt <= '0;
    end else if (r_state == ST_HDR && w_done) begin
      if (r_drop) rx_drop_cnt <= rx_drop_cnt + 16'd1;
      else        rx_pkt_cnt  <= rx_pkt_cnt + 16'd1;
    end
  end
`endif

  assign ff_rx_rdy      = r_rdy;
  assign wr_rq          = r_wr_rq;
  assign wr_adr         = r_wr_adr;
  assign wr_data_avalon = !r_wr_rq ? '0 : (r_hdr ? w_hdr_word : w_pk_word);
  assign byte_enable    = '1;
  assign pkt_done       = r_pkt_done;
  assign pkt_len        = r_pkt_len;

endmodule

// File: tb/tb_receive_packet_ddr.sv
// Self-checking bench for receive_packet_ddr: frame driver, DDR responder and
// a frame-level reference of the expected DDR image.
module tb_receive_packet_ddr;

  localparam int MAXL = 1518;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_enable;
  logic [24:0]  start_ram_addr;
  logic [7:0]   ff_rx_data;
  logic         ff_rx_sop, ff_rx_eop, ff_rx_err, ff_rx_dval;
  logic         ff_rx_rdy;
  logic         wr_rq;
  logic [24:0]  wr_adr;
  logic [255:0] wr_data_avalon;
  logic [31:0]  byte_enable;
  logic         action_done;
  logic         pkt_done;
  logic [10:0]  pkt_len;

  always #5 clk = ~clk;

  receive_packet_ddr dut (
    .clk_original   (clk),
    .rst_n          (rst_n),
    .rx_enable      (rx_enable),
    .start_ram_addr (start_ram_addr),
    .ff_rx_data     (ff_rx_data),
    .ff_rx_sop      (ff_rx_sop),
    .ff_rx_eop      (ff_rx_eop),
    .ff_rx_err      (ff_rx_err),
    .ff_rx_dval     (ff_rx_dval),
    .ff_rx_rdy      (ff_rx_rdy),
    .wr_rq          (wr_rq),
    .wr_adr         (wr_adr),
    .wr_data_avalon (wr_data_avalon),
    .byte_enable    (byte_enable),
    .action_done    (action_done),
    .pkt_done       (pkt_done),
    .pkt_len        (pkt_len)
  );

  typedef struct {
    logic [24:0]  adr;
    logic [255:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [10:0] dq[$];
  logic [7:0]  tx [0:2047];
  int          checks = 0;
  int          errors = 0;
  int          rsp_dly = 3;
  int          unstable = 0;
  int          rdy_viol = 0;

  // DDR responder: completes each request rsp_dly cycles after it appears
  initial begin : responder
    wr_t e;
    int  n;
    action_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && wr_rq) begin
        e.adr  = wr_adr;
        e.data = wr_data_avalon;
        n = 0;
        while (n < rsp_dly && rst_n && wr_rq) begin
          @(posedge clk); #1;
          n++;
          if (rst_n && wr_rq && (wr_adr !== e.adr || wr_data_avalon !== e.data)) unstable++;
        end
        if (rst_n && wr_rq) begin
          action_done = 1'b1;
          wq.push_back(e);
          @(posedge clk); #1;
          action_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (pkt_done) dq.push_back(pkt_len);
    if (wr_rq && ff_rx_rdy) rdy_viol++;
  end

  // Expected DDR word: 32-bit lanes ascending, big-endian bytes within a lane
  function automatic logic [255:0] exp_word(input int first, input int cnt);
    logic [255:0] w;
    logic [7:0]   q [4];
    w = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) q[j] = (4*k + j < cnt) ? tx[first + 4*k + j] : 8'h00;
      w[32*k +: 32] = {q[0], q[1], q[2], q[3]};
    end
    return w;
  endfunction

  // Drive n bytes tx[first..]; caller and task both sit on a negedge
  task automatic send_bytes(input int first, input int n, input bit sop_first,
                            input bit eop_last, input bit err_in, input int gap_max);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      ff_rx_data = tx[first + i];
      ff_rx_sop  = sop_first && (i == 0);
      ff_rx_eop  = eop_last && (i == n - 1);
      ff_rx_err  = ff_rx_eop ? err_in : 1'b0;
      ff_rx_dval = 1'b1;
      t = 0;
      while (!ff_rx_rdy && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        checks++; errors++;
        $display("FAIL rdy_timeout byte=%0d: ff_rx_rdy stuck 0, expected 1 within 200 cycles", i);
        ff_rx_dval = 1'b0;
        return;
      end
      @(negedge clk);
      ff_rx_dval = 1'b0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_err = 1'b0;
    end
  endtask

  task automatic test_frame(input int n, input logic [24:0] base, input bit err,
                            input int dly, input int gap);
    bit          dropped;
    int          k, nw, cnt, t;
    logic [10:0] el;
    wq.delete(); dq.delete();
    rsp_dly = dly;
    start_ram_addr = base;
    send_bytes(0, n, 1'b1, 1'b1, err, gap);
    t = 0;
    while (dq.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    dropped = err || (n > MAXL);
    if (dropped) begin
      k  = (n > MAXL) ? MAXL + 1 : n;
      nw = (k - 1) / 32;
      el = '0;
    end else begin
      nw = (n + 31) / 32;
      el = 11'(n);
    end
    checks++;
    if (dq.size() !== 1) begin
      errors++;
      $display("FAIL pkt_done_count n=%0d: got %0d pulses, expected 1", n, dq.size());
    end else begin
      checks++;
      if (dq[0] !== el) begin
        errors++;
        $display("FAIL pkt_len n=%0d: got %0d expected %0d", n, dq[0], el);
      end
    end
    checks++;
    if (wq.size() !== nw + 1) begin
      errors++;
      $display("FAIL write_count n=%0d: got %0d expected %0d", n, wq.size(), nw + 1);
    end
    for (int w = 0; w < nw; w++) begin
      if (w < wq.size()) begin
        cnt = n - 32*w;
        if (cnt > 32) cnt = 32;
        checks++;
        if (wq[w].adr !== base + 25'(w + 1)) begin
          errors++;
          $display("FAIL data_adr n=%0d w=%0d: got %h expected %h", n, w, wq[w].adr, base + 25'(w + 1));
        end
        checks++;
        if (wq[w].data !== exp_word(32*w, cnt)) begin
          errors++;
          $display("FAIL data_word n=%0d w=%0d: got %h expected %h", n, w, wq[w].data, exp_word(32*w, cnt));
        end
      end
    end
    if (wq.size() == nw + 1) begin
      checks++;
      if (wq[nw].adr !== base) begin
        errors++;
        $display("FAIL hdr_adr n=%0d: got %h expected %h", n, wq[nw].adr, base);
      end
      checks++;
      if (wq[nw].data !== 256'(el)) begin
        errors++;
        $display("FAIL hdr_word n=%0d: got %h expected %h", n, wq[nw].data, 256'(el));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_enable = 1'b1; start_ram_addr = '0;
    ff_rx_data = '0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_err = 1'b0; ff_rx_dval = 1'b0;
    #1;
    checks++;
    if (wr_rq !== 1'b0 || pkt_done !== 1'b0 || ff_rx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: wr_rq=%b pkt_done=%b rdy=%b expected 0 0 0", wr_rq, pkt_done, ff_rx_rdy);
    end
    checks++;
    if (pkt_len !== 11'd0 || wr_adr !== 25'd0 || wr_data_avalon !== 256'd0) begin
      errors++;
      $display("FAIL reset_data: pkt_len=%0d wr_adr=%h data=%h expected zeros", pkt_len, wr_adr, wr_data_avalon);
    end
    checks++;
    if (byte_enable !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL byte_enable: got %h expected ffffffff", byte_enable);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ff_rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL idle_rdy: got %b expected 1", ff_rx_rdy);
    end
  endtask

  task automatic test_frame64();
    for (int i = 0; i < 64; i++) tx[i] = 8'(i);
    test_frame(64, 25'h100, 1'b0, 3, 0);
    if (wq.size() == 3) begin
      checks++;
      if (wq[0].data[31:24] !== 8'h00 || wq[0].data[7:0] !== 8'h03) begin
        errors++;
        $display("FAIL frame64_lanes: got [31:24]=%h [7:0]=%h expected 00 03", wq[0].data[31:24], wq[0].data[7:0]);
      end
    end
  endtask

  task automatic test_frame33();
    logic [255:0] mask;
    for (int i = 0; i < 33; i++) tx[i] = 8'($urandom());
    test_frame(33, 25'h100, 1'b0, 2, 1);
    mask = ~(256'hFF << 24);
    if (wq.size() == 3) begin
      checks++;
      if (wq[1].data[31:24] !== tx[32] || (wq[1].data & mask) !== 256'd0) begin
        errors++;
        $display("FAIL frame33_tail: got %h expected byte %h at [31:24] only", wq[1].data, tx[32]);
      end
    end
  endtask

  task automatic test_one_byte();
    tx[0] = 8'hA5;
    test_frame(1, 25'h100, 1'b0, 3, 0);
    if (wq.size() == 2) begin
      checks++;
      if (wq[0].data[31:24] !== 8'hA5) begin
        errors++;
        $display("FAIL one_byte: got %h expected a5", wq[0].data[31:24]);
      end
    end
  endtask

  task automatic test_err_frame();
    for (int i = 0; i < 60; i++) tx[i] = 8'($urandom());
    test_frame(60, 25'h0400, 1'b1, 3, 0);
  endtask

  task automatic test_oversize();
    for (int i = 0; i < 1600; i++) tx[i] = 8'($urandom());
    test_frame(1600, 25'h1000, 1'b0, 1, 0);
  endtask

  task automatic test_long_wait();
    for (int i = 0; i < 70; i++) tx[i] = 8'($urandom());
    test_frame(70, 25'h0200, 1'b0, 20, 0);
  endtask

  task automatic test_sop_in_recv();
    int t;
    wq.delete(); dq.delete();
    rsp_dly = 3;
    for (int i = 0; i < 15; i++) tx[i] = 8'($urandom());
    start_ram_addr = 25'h200;
    send_bytes(0, 10, 1'b1, 1'b0, 1'b0, 0);
    start_ram_addr = 25'h300;
    send_bytes(10, 5, 1'b1, 1'b1, 1'b0, 0);
    t = 0;
    while (dq.size() == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dq.size() !== 1 || wq.size() !== 1) begin
      errors++;
      $display("FAIL sop_in_recv_count: got %0d done %0d writes, expected 1 1", dq.size(), wq.size());
    end else begin
      checks++;
      if (dq[0] !== 11'd0 || wq[0].adr !== 25'h200 || wq[0].data !== 256'd0) begin
        errors++;
        $display("FAIL sop_in_recv_hdr: got len=%0d adr=%h data=%h expected 0 200 0", dq[0], wq[0].adr, wq[0].data);
      end
    end
  endtask

  task automatic test_rx_disable();
    wq.delete(); dq.delete();
    rx_enable = 1'b0;
    for (int i = 0; i < 20; i++) tx[i] = 8'($urandom());
    send_bytes(0, 20, 1'b1, 1'b1, 1'b0, 0);
    repeat (30) @(negedge clk);
    checks++;
    if (wq.size() !== 0 || dq.size() !== 0) begin
      errors++;
      $display("FAIL rx_disable: got %0d writes %0d done, expected 0 0", wq.size(), dq.size());
    end
    rx_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t;
    wq.delete(); dq.delete();
    rsp_dly = 60;
    for (int i = 0; i < 32; i++) tx[i] = 8'($urandom());
    start_ram_addr = 25'h500;
    send_bytes(0, 32, 1'b1, 1'b0, 1'b0, 0);
    t = 0;
    while (!wr_rq && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (wr_rq !== 1'b1) begin
      errors++;
      $display("FAIL mid_wr_rq: got %b expected 1 after 32 bytes", wr_rq);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_rq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: wr_rq got %b expected 0", wr_rq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ff_rx_rdy !== 1'b1 || wr_rq !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b wr_rq=%b expected 1 0", ff_rx_rdy, wr_rq);
    end
    repeat (80) @(negedge clk);
    checks++;
    if (wq.size() !== 0 || dq.size() !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d writes %0d done, expected 0 0", wq.size(), dq.size());
    end
  endtask

  task automatic test_random();
    int          n;
    bit          err;
    logic [24:0] base;
    for (int it = 0; it < 8; it++) begin
      n    = $urandom_range(200, 1);
      err  = ($urandom_range(4, 0) == 0);
      base = 25'($urandom());
      for (int i = 0; i < n; i++) tx[i] = 8'($urandom());
      test_frame(n, base, err, $urandom_range(6, 1), $urandom_range(2, 0));
    end
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_frame33();
    test_one_byte();
    test_err_frame();
    test_oversize();
    test_long_wait();
    test_sop_in_recv();
    test_rx_disable();
    test_reset_mid();
    test_frame64();
    test_random();
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL request_stability: got %0d changes while wr_rq=1, expected 0", unstable);
    end
    checks++;
    if (rdy_viol !== 0) begin
      errors++;
      $display("FAIL rdy_during_write: got %0d cycles with rdy=1 and wr_rq=1, expected 0", rdy_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
